rw_write_responder: RTL and testbench

- Responder end of the RW-stage write channel (wvalid/waddr/wdata/wstrb/wid, bvalid/bid).
- Accepts byte-strobed 512-bit writes that bypass tags and go straight into the tile's RW data array.
- Also accepts full-line fills from the memory side and arbitrates them fairly against stage writes.
- Returns one in-order write response per stage write, and only after that write has been committed to the array.

---
 rtl/chronos_pkg.sv | 30 +++
 rtl/fifo.sv | 61 ++++++
 rtl/rw_write_responder.sv | 163 ++++++++++++++++
 tb/tb_rw_write_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/chronos_pkg.sv
// Shared types for the RW-stage datapath.
//   LOG_LINE_BYTES : log2 of bytes per data-array line (64-byte lines)
//   id_t           : thread id carried by stage writes and echoed on responses
//   resp_src_e     : origin of a registered array write (stage write or fill)
//   wr_stage_t     : contents of the single registered write stage
package chronos_pkg;

    localparam int LOG_LINE_BYTES = 6;
    localparam int LINE_BITS      = 512;
    localparam int LINE_BYTES     = LINE_BITS / 8;
    localparam int ADDR_LINE_W    = 32 - LOG_LINE_BYTES;

    typedef logic [3:0] id_t;

    typedef enum logic {
        RESP_SRC_STAGE = 1'b0,
        RESP_SRC_FILL  = 1'b1
    } resp_src_e;

    // line holds every address bit above the byte offset; the top level
    // keeps only the LOG_LINES bits that index its array.
    typedef struct packed {
        resp_src_e              src;
        logic [ADDR_LINE_W-1:0] line;
        logic [LINE_BITS-1:0]   data;
        logic [LINE_BYTES-1:0]  strb;
        id_t                    id;
    } wr_stage_t;

endpackage

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO.
//   clk, rstn : clock, synchronous active-low reset (clears pointers/count)
//   push/wdata: write an entry (caller guarantees !full)
//   pop       : consume head entry (caller guarantees !empty)
//   rdata     : head entry, valid while !empty
//   empty/full: occupancy flags
module fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);
    localparam logic [LOG_DEPTH:0]   CNT_ONE = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_DEPTH:0]   CNT_MAX = (LOG_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   count;

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/rw_write_responder.sv
// Responder end of the RW-stage write channel.
// Arbitrates byte-strobed stage writes against full-line fills, commits the
// winner to the data array one cycle after the grant, and returns one
// in-order response per stage write once it has been committed.
//   clk, rst              : clock, synchronous active-high reset
//   wvalid/wready/waddr/wdata/wstrb/wid : stage write request channel
//   bvalid/bready/bid     : write response channel
//   fill_valid/fill_ready/fill_addr/fill_data : memory-side line fills
//   arr_we/arr_addr/arr_wdata/arr_wstrb       : data-array write port
//   num_writes            : committed stage writes (wraps)
module rw_write_responder
    import chronos_pkg::*;
#(
    parameter int LOG_LINES      = 10,
    parameter int RESP_LOG_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [31:0]           waddr,
    input  logic [LINE_BITS-1:0]  wdata,
    input  logic [LINE_BYTES-1:0] wstrb,
    input  id_t                   wid,
    output logic                  bvalid,
    input  logic                  bready,
    output id_t                   bid,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [31:0]           fill_addr,
    input  logic [LINE_BITS-1:0]  fill_data,
    output logic                  arr_we,
    output logic [LOG_LINES-1:0]  arr_addr,
    output logic [LINE_BITS-1:0]  arr_wdata,
    output logic [LINE_BYTES-1:0] arr_wstrb,
    output logic [31:0]           num_writes
);

    localparam int CW = RESP_LOG_DEPTH + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(2 ** RESP_LOG_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

    logic [CW-1:0] credits;
    logic          prio_fill;     // 1: fill wins the next contended cycle
    logic          stage_elig;
    logic          fill_elig;
    logic          grant_stage;
    logic          grant_fill;
    logic          contended;
    logic          resp_push;
    logic          resp_pop;
    logic          q_empty;
    logic          q_full;
    wr_stage_t     wr_p0;
    wr_stage_t     wr_p1;
    logic          vld_p1;

    // ---- p0: arbitration and request capture ----
    always_comb begin
        stage_elig  = wvalid && (credits != '0);
        fill_elig   = fill_valid;
        // Nothing is granted while reset is held, so a request presented
        // during reset is never half-accepted.
        grant_stage = !rst && stage_elig && (!fill_elig || !prio_fill);
        grant_fill  = !rst && fill_elig && (!stage_elig || prio_fill);
        contended   = !rst && stage_elig && fill_elig;

        wr_p0.src  = RESP_SRC_STAGE;
        wr_p0.line = waddr[31:LOG_LINE_BYTES];
        wr_p0.data = wdata;
        wr_p0.strb = wstrb;
        wr_p0.id   = wid;
        if (grant_fill) begin
            wr_p0.src  = RESP_SRC_FILL;
            wr_p0.line = fill_addr[31:LOG_LINE_BYTES];
            wr_p0.data = fill_data;
            wr_p0.strb = '1;
            wr_p0.id   = '0;
        end
    end

    assign wready     = grant_stage;
    assign fill_ready = grant_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= grant_stage || grant_fill;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_stage || grant_fill) begin
            wr_p1 <= wr_p0;
        end
    end

    // ---- p1: array commit and response enqueue ----
    assign arr_we    = vld_p1;
    assign arr_addr  = wr_p1.line[LOG_LINES-1:0];
    assign arr_wdata = wr_p1.data;
    assign arr_wstrb = wr_p1.strb;

    assign resp_push = vld_p1 && (wr_p1.src == RESP_SRC_STAGE);
    assign resp_pop  = bvalid && bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits    <= CREDIT_MAX;
            prio_fill  <= 1'b0;
            num_writes <= '0;
        end else begin
            if (grant_stage && !resp_pop) begin
                credits <= credits - CREDIT_ONE;
            end else if (resp_pop && !grant_stage) begin
                credits <= credits + CREDIT_ONE;
            end
            if (contended) begin
                prio_fill <= !prio_fill;
            end
            if (resp_push) begin
                num_writes <= num_writes + 32'd1;
            end
        end
    end

    // Credits reserve queue space, so a push can never meet a full queue.
    fifo #(
        .WIDTH    ($bits(id_t)),
        .LOG_DEPTH(RESP_LOG_DEPTH)
    ) u_resp_q (
        .clk  (clk),
        .rstn (!rst),
        .push (resp_push),
        .wdata(wr_p1.id),
        .pop  (resp_pop),
        .rdata(bid),
        .empty(q_empty),
        .full (q_full)
    );

    // ---- p2: response presentation ----
    assign bvalid = !q_empty;

    logic unused_bits;
    assign unused_bits = ^{waddr[LOG_LINE_BYTES-1:0], fill_addr[LOG_LINE_BYTES-1:0],
                           wr_p1.line[ADDR_LINE_W-1:LOG_LINES], q_full};

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (credits <= CREDIT_MAX)
                else $error("credit counter above pool size");
            assert (!(grant_stage && !resp_pop && credits == '0))
                else $error("credit counter underflow");
            assert (!(resp_pop && !grant_stage && credits == CREDIT_MAX))
                else $error("credit counter overflow");
            assert (!(resp_push && q_full && !resp_pop))
                else $error("response push into full queue");
        end
    end

endmodule

// File: tb/tb_rw_write_responder.sv
module tb_rw_write_responder;
    import chronos_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [31:0]  waddr = '0;
    logic [511:0] wdata = '0;
    logic [63:0]  wstrb = '0;
    id_t          wid = '0;
    logic         bvalid;
    logic         bready = 1'b0;
    id_t          bid;
    logic         fill_valid = 1'b0;
    logic         fill_ready;
    logic [31:0]  fill_addr = '0;
    logic [511:0] fill_data = '0;
    logic         arr_we;
    logic [9:0]   arr_addr;
    logic [511:0] arr_wdata;
    logic [63:0]  arr_wstrb;
    logic [31:0]  num_writes;

    rw_write_responder #(.LOG_LINES(10), .RESP_LOG_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
        .wstrb(wstrb), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bid(bid),
        .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .arr_we(arr_we), .arr_addr(arr_addr), .arr_wdata(arr_wdata),
        .arr_wstrb(arr_wstrb), .num_writes(num_writes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]   line;
        logic [511:0] data;
        logic [63:0]  strb;
    } arr_t;

    arr_t         exp_arr [$];
    id_t          exp_bid [$];
    logic [511:0] tb_mem [0:1023];
    int           n_checks = 0;
    int           n_fail = 0;

    logic         o_wready, o_fill_ready, o_arr_we, o_bvalid;
    id_t          o_bid;
    logic [31:0]  o_num;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every array write and every consumed response is
    // compared against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (arr_we === 1'b1) begin
            if (exp_arr.size() == 0) begin
                check("arr_unexpected", 1, 0);
            end else begin
                arr_t e;
                e = exp_arr.pop_front();
                check("arr_addr", arr_addr, e.line);
                check("arr_wstrb", arr_wstrb, e.strb);
                check("arr_wdata", arr_wdata, e.data);
            end
            for (int b = 0; b < 64; b++) begin
                if (arr_wstrb[b]) tb_mem[arr_addr][8*b +: 8] = arr_wdata[8*b +: 8];
            end
        end
        if (bvalid === 1'b1 && bready === 1'b1) begin
            if (exp_bid.size() == 0) begin
                check("bid_unexpected", 1, 0);
            end else begin
                check("bid", bid, exp_bid.pop_front());
            end
        end
    end

    function automatic logic [31:0] la(input int line);
        return 32'(line) << 6;
    endfunction

    task automatic step(input logic wv, input logic [31:0] wa, input logic [511:0] wd,
                        input logic [63:0] ws, input id_t id, input logic fv,
                        input logic [31:0] fa, input logic [511:0] fd, input logic br);
        wvalid = wv; waddr = wa; wdata = wd; wstrb = ws; wid = id;
        fill_valid = fv; fill_addr = fa; fill_data = fd; bready = br;
        @(negedge clk);
        o_wready = wready; o_fill_ready = fill_ready; o_arr_we = arr_we;
        o_bvalid = bvalid; o_bid = bid; o_num = num_writes;
        if (wvalid && wready === 1'b1) begin
            exp_arr.push_back('{line: wa[15:6], data: wd, strb: ws});
            exp_bid.push_back(id);
        end
        if (fill_valid && fill_ready === 1'b1) begin
            exp_arr.push_back('{line: fa[15:6], data: fd, strb: '1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic br);
        step(0, '0, '0, '0, '0, 0, '0, '0, br);
    endtask

    task automatic wr(input int line, input logic [63:0] ws, input id_t id, input logic br);
        step(1, la(line), {16{32'hC0DE_0000 + 32'(id)}}, ws, id, 0, '0, '0, br);
    endtask

    initial begin
        int k;
        int j;
        logic [511:0] exp_line;

        // Reset: nothing granted while rst is high, outputs at reset values.
        rst = 1'b1;
        step(1, la(1), '1, '1, 4'd1, 1, la(2), '1, 1);
        check("rst_wready", o_wready, 0);
        check("rst_fill_ready", o_fill_ready, 0);
        step(0, '0, '0, '0, '0, 0, '0, '0, 1);
        check("rst_bvalid", o_bvalid, 0);
        check("rst_arr_we", o_arr_we, 0);
        check("rst_num_writes", o_num, 0);
        rst = 1'b0;

        // Single write: line 4, bytes 4..7, id 3.
        step(1, 32'h0000_0104, {16{32'h1234_5678}}, 64'h0000_0000_0000_00F0, 4'd3, 0, '0, '0, 1);
        check("t1_wready", o_wready, 1);
        idle(1);
        check("t1_arr_we_T1", o_arr_we, 1);
        check("t1_bvalid_T1", o_bvalid, 0);
        idle(1);
        check("t1_bvalid_T2", o_bvalid, 1);
        check("t1_bid_T2", o_bid, 3);
        check("t1_num_writes", o_num, 1);
        idle(1);

        // Credit exhaustion with bready low; fills still flow when blocked.
        k = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, la(20 + k), {16{32'hA000_0000 + 32'(k)}}, '1, id_t'(k),
                 (i >= 4), la(100 + i), {16{32'hF111_0000 + 32'(i)}}, 0);
            check("t2_wready", o_wready, (i < 4));
            check("t2_fill_ready", o_fill_ready, (i >= 4));
            if (o_wready) k++;
        end
        check("t2_accepted", k, 4);
        j = 0;
        while (k < 6 && j < 10) begin
            step(1, la(20 + k), {16{32'hA000_0000 + 32'(k)}}, '1, id_t'(k), 0, '0, '0, 1);
            check("t2_resume_wready", o_wready, (j != 0));
            if (o_wready) k++;
            j++;
        end
        check("t2_resume_cycles", j, 3);
        for (int i = 0; i < 8; i++) idle(1);

        // Contention: alternate grants starting with the stage side.
        k = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, la(30 + k), {16{32'hB000_0000 + 32'(k)}}, 64'h00FF, id_t'(10 + k),
                 1, la(40 + i), {16{32'hD000_0000 + 32'(i)}}, 1);
            check("t3_wready", o_wready, (i % 2 == 0));
            check("t3_fill_ready", o_fill_ready, (i % 2 == 1));
            if (o_wready) k++;
        end
        for (int i = 0; i < 4; i++) idle(1);

        // Same-line ordering: fill then stage merges; stage then fill overwrites.
        step(0, '0, '0, '0, '0, 1, la(7), {64{8'hAA}}, 1);
        check("t4_fill_ready", o_fill_ready, 1);
        step(1, la(7), {{63{8'h11}}, 8'h55}, 64'h1, 4'd6, 0, '0, '0, 1);
        check("t4_wready", o_wready, 1);
        step(1, la(8), {{63{8'h11}}, 8'h55}, 64'h1, 4'd7, 0, '0, '0, 1);
        step(0, '0, '0, '0, '0, 1, la(8), {64{8'hAA}}, 1);
        for (int i = 0; i < 4; i++) idle(1);
        exp_line = {{63{8'hAA}}, 8'h55};
        check("t4_line7_merge", tb_mem[7], exp_line);
        exp_line = {64{8'hAA}};
        check("t4_line8_overwrite", tb_mem[8], exp_line);

        // Sustained stream with simultaneous accept and credit return.
        for (int i = 0; i < 3; i++) begin
            wr(50 + i, 64'hFFFF, id_t'(i), 0);
            check("t5_fill_up", o_wready, 1);
        end
        for (int i = 3; i < 13; i++) begin
            wr(50 + i, 64'hFFFF, id_t'(i), 1);
            check("t5_stream_wready", o_wready, 1);
        end
        for (int i = 0; i < 3; i++) begin
            wr(70 + i, 64'hFFFF, id_t'(13 + i), 0);
            check("t5_credit_left", o_wready, (i == 0));
        end
        for (int i = 0; i < 8; i++) idle(1);

        // Reset mid-stream: two responses queued, one write in flight.
        wr(80, 64'h3, 4'd1, 0);
        wr(81, 64'h3, 4'd2, 0);
        idle(0);
        idle(0);
        wr(82, 64'h3, 4'd3, 0);
        check("t6_inflight_accept", o_wready, 1);
        rst = 1'b1;
        idle(0);
        rst = 1'b0;
        exp_bid.delete();
        wr(83, 64'h3, 4'd9, 0);
        check("t6_bvalid_after_rst", o_bvalid, 0);
        check("t6_arr_we_after_rst", o_arr_we, 0);
        check("t6_wready_after_rst", o_wready, 1);
        check("t6_num_after_rst", o_num, 0);
        for (int i = 0; i < 4; i++) idle(1);
        check("t6_num_final", o_num, 1);

        check("final_arr_pending", exp_arr.size(), 0);
        check("final_bid_pending", exp_bid.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
